// File: rtl/partial_fm_reader_if.sv
// Output stream bundle of the partial feature-map reader.
// The reader drives the element, its index and last flag; the consumer drives ready.
interface partial_fm_reader_if;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [7:0]  out_index;
  logic        out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_index,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_index,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/partial_fm_reader.sv
// Consumer end of the partial feature-map interface. On a rising edge of the
// producer's resting level the three partial maps, bias and ReLU enable are
// snapshotted; the channel-combined elements (IK1+IK2+IK3+bias, optional
// ReLU, Q1.15 saturation) are then streamed one per cycle over valid/ready.
module partial_fm_reader #(
  parameter  int op_size       = 4,
  localparam int total_outputs = op_size * op_size
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         resting,
  input  logic [16*total_outputs-1:0]  IK1,
  input  logic [16*total_outputs-1:0]  IK2,
  input  logic [16*total_outputs-1:0]  IK3,
  input  logic [15:0]                  bias,
  input  logic                         relu_en,
  partial_fm_reader_if.master          out,
  output logic                         busy,
  output logic                         done,
  output logic                         sat_flag
);

  localparam int IDX_W = $clog2(total_outputs + 1);
  localparam int SEL_W = $clog2(16 * total_outputs);
  localparam logic [IDX_W-1:0] N_IDX    = IDX_W'(total_outputs);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(total_outputs - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  // Sum of four sign-extended Q1.15 operands (18 bits cannot overflow),
  // optional ReLU, then clamp. Bit 16 reports that clamping changed the value.
  function automatic logic [16:0] combine(input logic [15:0] a, input logic [15:0] b,
                                          input logic [15:0] c, input logic [15:0] bs,
                                          input logic relu);
    logic signed [17:0] sum;
    logic signed [17:0] r;
    logic [15:0]        res;
    logic               sat;
    sum = $signed({{2{a[15]}}, a}) + $signed({{2{b[15]}}, b})
        + $signed({{2{c[15]}}, c}) + $signed({{2{bs[15]}}, bs});
    if (relu && sum[17]) begin
      r = 18'sd0;
    end else begin
      r = sum;
    end
    if (r > 18'sd32767) begin
      res = 16'h7FFF;
      sat = 1'b1;
    end else if (r < -18'sd32768) begin
      res = 16'h8000;
      sat = 1'b1;
    end else begin
      res = r[15:0];
      sat = 1'b0;
    end
    return {sat, res};
  endfunction

  logic [1:0]               state_q, state_d;
  logic                     resting_q;
  logic [IDX_W-1:0]         rd_idx_q, rd_idx_d;
  logic                     out_valid_q, out_valid_d;
  logic [15:0]              out_data_q, out_data_d;
  logic [7:0]               out_index_q, out_index_d;
  logic                     out_last_q, out_last_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     sat_q, sat_d;
  logic [16*total_outputs-1:0] ik1_q, ik2_q, ik3_q;
  logic [15:0]              bias_q;
  logic                     relu_q;

  logic                     snap_s;
  logic                     load_s;
  logic                     accept_s;
  logic [SEL_W-1:0]         sel_s;
  logic [16:0]              elem_s;

  assign snap_s   = (state_q == ST_IDLE) & resting & ~resting_q;
  assign load_s   = (state_q == ST_STREAM) & (~out_valid_q | out.out_ready) & (rd_idx_q < N_IDX);
  assign accept_s = out_valid_q & out.out_ready;
  assign sel_s    = SEL_W'({rd_idx_q, 4'b0000});
  assign elem_s   = combine(ik1_q[sel_s +: 16], ik2_q[sel_s +: 16], ik3_q[sel_s +: 16],
                            bias_q, relu_q);

  // Next-state logic for the IDLE/STREAM/DONE sequencer and the output register.
  always_comb begin
    state_d     = state_q;
    rd_idx_d    = rd_idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    out_last_d  = out_last_q;
    sat_d       = sat_q;
    case (state_q)
      ST_IDLE: begin
        if (snap_s) begin
          sat_d    = 1'b0;
          rd_idx_d = '0;
          state_d  = ST_STREAM;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (load_s) begin
          out_valid_d = 1'b1;
          out_data_d  = elem_s[15:0];
          out_index_d = 8'(rd_idx_q);
          out_last_d  = (rd_idx_q == LAST_IDX);
          sat_d       = sat_q | elem_s[16];
          rd_idx_d    = rd_idx_q + IDX_W'(1);
        end else if (accept_s) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_STREAM;
          end
        end else begin
          state_d = ST_STREAM;
        end
      end
      ST_DONE: begin
        if (!resting) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_STREAM);
    done_d = (state_d == ST_DONE);
  end

  // Control and output registers; cleared asynchronously by the active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      resting_q   <= 1'b0;
      rd_idx_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 16'h0000;
      out_index_q <= 8'h00;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      resting_q   <= resting;
      rd_idx_q    <= rd_idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      sat_q       <= sat_d;
    end
  end

  // Snapshot buffers: loaded only on a snapshot edge, so the producer may change freely afterwards.
  always_ff @(posedge clk) begin
    if (snap_s) begin
      ik1_q  <= IK1;
      ik2_q  <= IK2;
      ik3_q  <= IK3;
      bias_q <= bias;
      relu_q <= relu_en;
    end else begin
      ik1_q  <= ik1_q;
      ik2_q  <= ik2_q;
      ik3_q  <= ik3_q;
      bias_q <= bias_q;
      relu_q <= relu_q;
    end
  end

  assign out.out_valid = out_valid_q;
  assign out.out_data  = out_data_q;
  assign out.out_index = out_index_q;
  assign out.out_last  = out_last_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign sat_flag      = sat_q;

endmodule
